// File: rtl/iob_iddr_scan_rx.sv
// rtl/iob_iddr_scan_rx.sv - DUT serial readback capture, deserialiser and 2-entry word buffer (option: SCAN_RX_IDDR_EN)
module iob_iddr_scan_rx #(
    parameter int WORD_W  = 16,
    parameter int FRAME_W = 8
) (
    input  logic               pl_clk1,
    input  logic               pl_rstn,
    input  logic               dut_scan_out_i,
    input  logic               scan_sample_i,
    input  logic               start_i,
    input  logic [FRAME_W-1:0] frame_len_i,
    input  logic               abort_i,
    output logic [WORD_W-1:0]  word_o,
    output logic               word_valid_o,
    input  logic               word_ready_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               overflow_o
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    logic stage1;
    logic rx_bit_q;

    // Stage 1 sits in the I/O tile and is never reset; only the fabric flop sees pl_rstn.
`ifdef SCAN_RX_IDDR_EN
    logic iddr_q2;

    IDDR #(
        .DDR_CLK_EDGE ("SAME_EDGE_PIPELINED"),
        .INIT_Q1      (1'b0),
        .INIT_Q2      (1'b0),
        .SRTYPE       ("SYNC")
    ) u_iddr (
        .Q1 (stage1),
        .Q2 (iddr_q2),
        .C  (pl_clk1),
        .CE (1'b1),
        .D  (dut_scan_out_i),
        .R  (1'b0),
        .S  (1'b0)
    );
`else
    (* IOB = "TRUE" *) logic pad_q;

    always_ff @(posedge pl_clk1) begin
        pad_q <= dut_scan_out_i;
    end

    assign stage1 = pad_q;
`endif

    always_ff @(posedge pl_clk1) begin
        if (!pl_rstn) begin
            rx_bit_q <= 1'b0;
        end else begin
            rx_bit_q <= stage1;
        end
    end

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]  words_left_q, words_left_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [WORD_W-1:0]   word_next;
    logic                push;
    logic                frame_start;

    assign word_next = {shreg_q[WORD_W-2:0], rx_bit_q};

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        words_left_d = words_left_q;
        shreg_d      = shreg_q;
        push         = 1'b0;
        frame_start  = 1'b0;
        if (abort_i) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            shreg_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        frame_start = 1'b1;
                        if (frame_len_i != '0) begin
                            words_left_d = frame_len_i;
                            bit_cnt_d    = '0;
                            shreg_d      = '0;
                            state_d      = ST_SHIFT;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (scan_sample_i) begin
                        shreg_d = word_next;
                        if (bit_cnt_q == BIT_LAST) begin
                            push         = 1'b1;
                            bit_cnt_d    = '0;
                            words_left_d = words_left_q - FRAME_W'(1);
                            if (words_left_q == FRAME_W'(1)) begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge pl_clk1) begin
        if (!pl_rstn) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            words_left_q <= '0;
            shreg_q      <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            words_left_q <= words_left_d;
            shreg_q      <= shreg_d;
        end
    end

    logic [WORD_W-1:0] head_q, head_d;
    logic [WORD_W-1:0] tail_q, tail_d;
    logic [1:0]        count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              pop;

    assign pop = (count_q != 2'd0) && word_ready_i;

    // A full buffer that pops in the same cycle still has room for the incoming word.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (frame_start) begin
            overflow_d = 1'b0;
        end
        if (abort_i) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        head_d  = word_next;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_d = word_next;
                    end else if (push) begin
                        tail_d  = word_next;
                        count_d = 2'd2;
                    end else if (pop) begin
                        count_d = 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_d = tail_q;
                        if (push) begin
                            tail_d = word_next;
                        end else begin
                            count_d = 2'd1;
                        end
                    end else if (push) begin
                        overflow_d = 1'b1;
                    end
                end
                default: begin
                    count_d = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge pl_clk1) begin
        if (!pl_rstn) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign word_o       = head_q;
    assign word_valid_o = (count_q != 2'd0);
    assign busy_o       = (state_q == ST_SHIFT);
    assign done_o       = (state_q == ST_DONE);
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_iob_iddr_scan_rx.sv
// tb/tb_iob_iddr_scan_rx.sv - directed self-checking bench for iob_iddr_scan_rx
module tb_iob_iddr_scan_rx;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        pad = 1'b0;
    logic        sample = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  frame_len = 8'd0;
    logic        abort = 1'b0;
    logic [15:0] word;
    logic        word_valid;
    logic        ready = 1'b0;
    logic        busy;
    logic        done;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    iob_iddr_scan_rx #(.WORD_W(16), .FRAME_W(8)) dut (
        .pl_clk1        (clk),
        .pl_rstn        (rstn),
        .dut_scan_out_i (pad),
        .scan_sample_i  (sample),
        .start_i        (start),
        .frame_len_i    (frame_len),
        .abort_i        (abort),
        .word_o         (word),
        .word_valid_o   (word_valid),
        .word_ready_i   (ready),
        .busy_o         (busy),
        .done_o         (done),
        .overflow_o     (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pad settles three cycles before the strobe, well past the two-flop capture latency.
    task automatic send_bits(input logic [15:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            pad = w[i];
            tick();
            tick();
            tick();
            sample = 1'b1;
            tick();
            sample = 1'b0;
        end
    endtask

    task automatic do_start(input logic [7:0] len);
        start = 1'b1;
        frame_len = len;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // Reset with the pad toggling
        for (int i = 0; i < 4; i++) begin
            pad = ~pad;
            sample = 1'b1;
            tick();
        end
        sample = 1'b0;
        check("rst_word", 32'(word), 32'h0);
        check("rst_valid", 32'(word_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        rstn = 1'b1;
        tick();
        tick();
        tick();
        check("post_rst_valid", 32'(word_valid), 32'h0);

        // Two-word frame, consumer always ready
        ready = 1'b1;
        do_start(8'd2);
        check("t1_busy_rise", 32'(busy), 32'h1);
        send_bits(16'hA5C3, 15, 0);
        check("t1_w0_valid", 32'(word_valid), 32'h1);
        check("t1_w0_data", 32'(word), 32'hA5C3);
        check("t1_w0_nodone", 32'(done), 32'h0);
        send_bits(16'h0F0F, 15, 0);
        check("t1_w1_valid", 32'(word_valid), 32'h1);
        check("t1_w1_data", 32'(word), 32'h0F0F);
        check("t1_done", 32'(done), 32'h1);
        check("t1_busy_fall", 32'(busy), 32'h0);
        tick();
        check("t1_done_end", 32'(done), 32'h0);
        check("t1_drained", 32'(word_valid), 32'h0);

        // Three words into a stalled consumer: third word dropped
        ready = 1'b0;
        do_start(8'd3);
        send_bits(16'h1111, 15, 0);
        send_bits(16'h2222, 15, 0);
        check("t2_no_ovf_yet", 32'(overflow), 32'h0);
        send_bits(16'h3333, 15, 0);
        check("t2_ovf", 32'(overflow), 32'h1);
        check("t2_done", 32'(done), 32'h1);
        check("t2_head_hold", 32'(word), 32'h1111);
        ready = 1'b1;
        tick();
        check("t2_second", 32'(word), 32'h2222);
        check("t2_second_valid", 32'(word_valid), 32'h1);
        tick();
        check("t2_empty", 32'(word_valid), 32'h0);
        check("t2_ovf_sticky", 32'(overflow), 32'h1);

        // Zero-length frame; its start also clears overflow
        do_start(8'd0);
        check("t3_done", 32'(done), 32'h1);
        check("t3_busy", 32'(busy), 32'h0);
        check("t3_ovf_clr", 32'(overflow), 32'h0);
        tick();
        check("t3_done_end", 32'(done), 32'h0);
        check("t3_nowords", 32'(word_valid), 32'h0);

        // Abort mid-word with a full buffer, then a clean frame
        ready = 1'b0;
        do_start(8'd4);
        send_bits(16'h5555, 15, 0);
        send_bits(16'hAAAA, 15, 0);
        send_bits(16'hFFFF, 15, 9);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_flushed", 32'(word_valid), 32'h0);
        check("t4_idle", 32'(busy), 32'h0);
        check("t4_nodone", 32'(done), 32'h0);
        tick();
        check("t4_nodone2", 32'(done), 32'h0);
        ready = 1'b1;
        do_start(8'd1);
        send_bits(16'h1234, 15, 0);
        check("t4_word", 32'(word), 32'h1234);
        check("t4_valid", 32'(word_valid), 32'h1);
        check("t4_done", 32'(done), 32'h1);
        tick();
        check("t4_single", 32'(word_valid), 32'h0);

        // Strobes in IDLE and a mid-frame start are ignored
        pad = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            sample = 1'b1;
            tick();
        end
        sample = 1'b0;
        check("t5_idle_samples", 32'(word_valid), 32'h0);
        do_start(8'd1);
        send_bits(16'hBEEF, 15, 8);
        do_start(8'd5);
        check("t5_still_busy", 32'(busy), 32'h1);
        send_bits(16'hBEEF, 7, 0);
        check("t5_word", 32'(word), 32'hBEEF);
        check("t5_done", 32'(done), 32'h1);
        tick();
        check("t5_idle", 32'(busy), 32'h0);
        check("t5_single", 32'(word_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
